// File: rtl/mema_ctrl.sv
// mema_ctrl: A-operand buffer sequencer that loads DIM rows, then streams one operand window.
// Define MEMA_CTRL_ABORT_EN to add the abort input.
module mema_ctrl #(
   parameter int BITS_AB = 8,
   parameter int DIM = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic load_req,
   input  logic row_valid,
   output logic row_ready,
   input  logic signed [BITS_AB-1:0] row_data [DIM-1:0],
   input  logic go,
`ifdef MEMA_CTRL_ABORT_EN
   input  logic abort,
`endif
   output logic a_en,
   output logic a_wren,
   output logic [$clog2(DIM)-1:0] a_row,
   output logic signed [BITS_AB-1:0] a_in [DIM-1:0],
   output logic loaded,
   output logic busy,
   output logic done
);
   localparam int STREAM_LEN = 3*DIM-2;
   localparam int RW = $clog2(DIM);
   localparam int SW = $clog2(3*DIM);
   localparam logic [RW:0] LAST_ROW = (RW+1)'(DIM-1);
   localparam logic [SW-1:0] LAST_BEAT = SW'(STREAM_LEN-1);
   localparam logic [RW:0] ROW_ONE = (RW+1)'(1);
   localparam logic [SW-1:0] BEAT_ONE = SW'(1);

   typedef enum logic [2:0] {IDLE, LOAD, LOADED, STREAM, DONE} state_t;

   state_t state, state_nx;
   logic [RW:0] row_cnt;
   logic [SW-1:0] stream_cnt;
   logic kill, beat;

`ifdef MEMA_CTRL_ABORT_EN
   assign kill = abort && (state == LOAD || state == LOADED || state == STREAM);
`else
   assign kill = 1'b0;
`endif
   assign row_ready = state == LOAD;
   assign busy = state != IDLE;
   assign beat = row_valid && row_ready && !kill;

   always_comb begin
      state_nx = state;
      if (kill) state_nx = IDLE;
      else
         unique case (state)
            IDLE:    if (load_req) state_nx = LOAD;
            LOAD:    if (beat && row_cnt == LAST_ROW) state_nx = LOADED;
            LOADED:  if (go) state_nx = STREAM;
            STREAM:  if (stream_cnt == LAST_BEAT) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
   end

   // Status strobes are flopped from the next state so they are glitch-free.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         row_cnt <= '0;
         stream_cnt <= '0;
         a_wren <= 1'b0;
         a_en <= 1'b0;
         loaded <= 1'b0;
         done <= 1'b0;
         a_row <= '0;
         a_in <= '{default: '0};
      end else begin
         state <= state_nx;
         a_wren <= beat;
         a_en <= state_nx == STREAM;
         loaded <= state_nx == LOADED;
         done <= state_nx == DONE;
         if (beat) begin
            a_in <= row_data;
            a_row <= row_cnt[RW-1:0];
         end
         row_cnt <= (state == IDLE && load_req) ? '0 : beat ? row_cnt + ROW_ONE : row_cnt;
         stream_cnt <= (state == LOADED && go) ? '0 : state == STREAM ? stream_cnt + BEAT_ONE : stream_cnt;
      end
   end
endmodule

// File: tb/tb_mema_ctrl.sv
// tb_mema_ctrl: directed bench comparing mema_ctrl against a phase/timing model every cycle.
module tb_mema_ctrl;
   localparam int DIM = 8;
   localparam int SLEN = 3*DIM-2;
   localparam int P_IDLE = 0, P_LOAD = 1, P_LOADED = 2, P_STREAM = 3, P_DONE = 4;

   logic clk = 1'b0, rst = 1'b1, load_req = 1'b0, row_valid = 1'b0, go = 1'b0;
`ifdef MEMA_CTRL_ABORT_EN
   logic abort = 1'b0;
`endif
   logic signed [7:0] row_data [DIM-1:0];
   logic row_ready, a_en, a_wren, loaded, busy, done;
   logic [2:0] a_row;
   logic signed [7:0] a_in [DIM-1:0];
   int vectors = 0, miscompares = 0;

   always #5 clk = ~clk;

   mema_ctrl #(.BITS_AB(8), .DIM(DIM)) dut (
      .clk(clk), .rst(rst), .load_req(load_req), .row_valid(row_valid), .row_ready(row_ready),
      .row_data(row_data), .go(go),
`ifdef MEMA_CTRL_ABORT_EN
      .abort(abort),
`endif
      .a_en(a_en), .a_wren(a_wren), .a_row(a_row), .a_in(a_in),
      .loaded(loaded), .busy(busy), .done(done)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", nm, $signed(act), $signed(exp));
      end
   endtask

   // Behavioural model: phase plus edge-count arithmetic for the stream window
   int phase = P_IDLE, rows = 0, go_edge = 0, cyc = 0, e_row = 0;
   logic e_wren = 1'b0;
   logic signed [7:0] e_in [DIM-1:0];

   always @(posedge clk) begin
      bit ab, beat;
      cyc++;
      ab = 1'b0;
`ifdef MEMA_CTRL_ABORT_EN
      ab = abort && (phase == P_LOAD || phase == P_LOADED || phase == P_STREAM);
`endif
      beat = phase == P_LOAD && row_valid && !ab;
      if (rst) begin
         phase = P_IDLE;
         rows = 0;
         e_wren = 1'b0;
         e_row = 0;
         foreach (e_in[i]) e_in[i] = 8'sd0;
      end else begin
         e_wren = beat;
         if (beat) begin
            e_row = rows;
            e_in = row_data;
            rows++;
         end
         if (ab) phase = P_IDLE;
         else case (phase)
            P_IDLE:   if (load_req) begin phase = P_LOAD; rows = 0; end
            P_LOAD:   if (rows == DIM) phase = P_LOADED;
            P_LOADED: if (go) begin phase = P_STREAM; go_edge = cyc; end
            P_STREAM: if (cyc == go_edge + SLEN) phase = P_DONE;
            default:  phase = P_IDLE;
         endcase
      end
   end

   logic chk_en = 1'b0;
   always @(negedge clk) if (chk_en) begin
      chk("row_ready", 32'(row_ready), 32'(phase == P_LOAD));
      chk("a_en", 32'(a_en), 32'(phase == P_STREAM));
      chk("loaded", 32'(loaded), 32'(phase == P_LOADED));
      chk("done", 32'(done), 32'(phase == P_DONE));
      chk("busy", 32'(busy), 32'(phase != P_IDLE));
      chk("a_wren", 32'(a_wren), 32'(e_wren));
      chk("a_row", 32'(a_row), 32'(e_row[2:0]));
      for (int c = 0; c < DIM; c++) chk("a_in", 32'(a_in[c]), 32'(e_in[c]));
   end

   // Event recorder used by the literal expectations
   int wr_q[$];
   int en_cnt = 0, done_cnt = 0, last_en_cyc = 0, done_cyc = 0;
   logic signed [7:0] last_in3 = 8'sd0;
   always @(negedge clk) begin
      if (a_wren === 1'b1) begin
         wr_q.push_back(int'(a_row));
         last_in3 = a_in[3];
      end
      if (a_en === 1'b1) begin en_cnt++; last_en_cyc = cyc; end
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
   end

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic do_load(input bit gap, input int off, input int upto);
      int r, k;
      wr_q.delete();
      load_req = 1'b1;
      tick;
      load_req = 1'b0;
      r = 0;
      k = 0;
      while (r < upto && k < 40) begin
         row_valid = !(gap && k % 2 == 1);
         for (int c = 0; c < DIM; c++) row_data[c] = 8'(r*8 + c + off);
         tick;
         if (row_valid) r++;
         k++;
      end
      row_valid = 1'b0;
      chk("load_bound", 32'(r), 32'(upto));
   endtask

   task automatic check_full_load(input int in3);
      chk("wr_count", 32'(wr_q.size()), 32'd8);
      foreach (wr_q[i]) chk("wr_order", 32'(wr_q[i]), 32'(i));
      chk("loaded_lit", 32'(loaded), 32'd1);
      chk("ready_lit", 32'(row_ready), 32'd0);
      chk("last_in3", 32'(last_in3), 32'(in3));
   endtask

   task automatic do_stream(input int abort_at);
      en_cnt = 0;
      done_cnt = 0;
      go = 1'b1;
      tick;
      go = 1'b0;
      for (int k = 0; k < 30; k++) begin
         go = k == 5;
         load_req = k == 5;
`ifdef MEMA_CTRL_ABORT_EN
         abort = k == abort_at;
`endif
         tick;
      end
      go = 1'b0;
      load_req = 1'b0;
`ifdef MEMA_CTRL_ABORT_EN
      abort = 1'b0;
`endif
      chk("stream_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      foreach (row_data[i]) row_data[i] = 8'sd0;
      tick;
      chk_en = 1'b1;
      tick;
      rst = 1'b0;
      repeat (5) tick;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_ready", 32'(row_ready), 32'd0);
      chk("idle_wren", 32'(a_wren), 32'd0);

      do_load(1'b0, 0, 8);
      check_full_load(59);
      do_stream(-1);
      chk("en_cycles", 32'(en_cnt), 32'd22);
      chk("done_pulses", 32'(done_cnt), 32'd1);
      chk("done_after_en", 32'(done_cyc - last_en_cyc), 32'd1);

      do_load(1'b1, -64, 8);
      check_full_load(-5);

      do_load(1'b0, 0, 3);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("rst_busy", 32'(busy), 32'd0);
      do_load(1'b0, 10, 8);
      chk("first_row", 32'(wr_q.size() > 0 ? wr_q[0] : -1), 32'd0);
      check_full_load(69);
      do_stream(-1);
      chk("en_cycles2", 32'(en_cnt), 32'd22);
      chk("done_pulses2", 32'(done_cnt), 32'd1);

`ifdef MEMA_CTRL_ABORT_EN
      do_load(1'b0, 0, 8);
      do_stream(9);
      chk("abort_en_cycles", 32'(en_cnt), 32'd10);
      chk("abort_no_done", 32'(done_cnt), 32'd0);
      do_load(1'b0, 1, 8);
      check_full_load(60);
`endif

      repeat (3) tick;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
